// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: mode codes, FSM states, flag bundle.
package alu_pkg;

  localparam int unsigned MODE_W = 4;

  localparam logic [MODE_W-1:0] ALU_ADD   = 4'h0;
  localparam logic [MODE_W-1:0] ALU_SUB   = 4'h1;
  localparam logic [MODE_W-1:0] ALU_AND   = 4'h2;
  localparam logic [MODE_W-1:0] ALU_OR    = 4'h3;
  localparam logic [MODE_W-1:0] ALU_XOR   = 4'h4;
  localparam logic [MODE_W-1:0] ALU_NOTA  = 4'h5;
  localparam logic [MODE_W-1:0] ALU_SLA   = 4'h6;
  localparam logic [MODE_W-1:0] ALU_SLL   = 4'h7;
  localparam logic [MODE_W-1:0] ALU_SRA   = 4'h8;
  localparam logic [MODE_W-1:0] ALU_SRL   = 4'h9;
  localparam logic [MODE_W-1:0] ALU_ADDSH = 4'hA;
  localparam logic [MODE_W-1:0] ALU_MUL   = 4'hB;
  localparam logic [MODE_W-1:0] ALU_DIVU  = 4'hC;
  localparam logic [MODE_W-1:0] ALU_REMU  = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic dbz;
    logic illegal;
  } alu_flags_t;

  function automatic logic is_divide(input logic [MODE_W-1:0] m);
    return (m == ALU_DIVU) || (m == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative datapath: shift-add signed multiply (magnitudes, sign fixed at the end)
// and restoring unsigned divide/remainder, one bit per clock for WIDTH clocks.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_mul,
  input  logic             want_rem,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] result_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             busy;
  logic             mul_q;
  logic             rem_q;
  logic             neg_q;
  logic [CNT_W-1:0] count_q;
  // acc: product accumulator or partial remainder; x: multiplicand or dividend/quotient; y: multiplier or divisor
  logic [WIDTH-1:0] acc_q, x_q, y_q;
  logic [WIDTH-1:0] acc_n, x_n;
  logic [WIDTH:0]   shifted, trial;
  logic             qbit;

  // One iteration step for the current mode
  always_comb begin
    shifted = {acc_q, x_q[WIDTH-1]};
    trial   = shifted - {1'b0, y_q};
    qbit    = ~trial[WIDTH];
    if (mul_q) begin
      acc_n = y_q[0] ? (acc_q + x_q) : acc_q;
      x_n   = x_q << 1;
    end else begin
      acc_n = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      x_n   = {x_q[WIDTH-2:0], qbit};
    end
  end

  assign done_c   = busy && (count_q == CNT_W'(WIDTH - 1));
  assign result_c = mul_q ? (neg_q ? -acc_n : acc_n) : (rem_q ? acc_n : x_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      mul_q   <= 1'b0;
      rem_q   <= 1'b0;
      neg_q   <= 1'b0;
      count_q <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      mul_q   <= is_mul;
      rem_q   <= want_rem;
      neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
      count_q <= '0;
      acc_q   <= '0;
      x_q     <= (is_mul && a[WIDTH-1]) ? -a : a;
      y_q     <= (is_mul && b[WIDTH-1]) ? -b : b;
    end else if (busy) begin
      acc_q   <= acc_n;
      x_q     <= x_n;
      if (mul_q) y_q <= y_q >> 1;
      count_q <= count_q + CNT_W'(1);
      if (done_c) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_alu.sv
// Handshaked EX-stage ALU: single-cycle ops plus iterative MUL/DIVU/REMU,
// with a held output register under out_valid/out_ready.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             dbz,
  output logic             illegal
);

  alu_state_e       state, state_n;
  alu_flags_t       flags_q, flags_n, sc_flags;
  logic [WIDTH-1:0] add_b, sc_res, res_n, iter_res;
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;
  logic             accept, dbz_c, launch, load, start, iter_done;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign dbz_c    = is_divide(mode) && (op_b == '0);
  assign launch   = accept && ((mode == ALU_MUL) || (is_divide(mode) && !dbz_c));

  assign shamt = op_b[SHW-1:0];
  assign add_b = (mode == ALU_ADDSH) ? (op_b << 2) : op_b;
  assign sum   = {1'b0, op_a} + {1'b0, add_b};
  assign diff  = {1'b0, op_a} - {1'b0, op_b};

  // Single-cycle results, including the divide-by-zero and illegal shortcuts
  always_comb begin
    sc_res   = '0;
    sc_flags = '0;
    case (mode)
      ALU_ADD, ALU_ADDSH: begin
        sc_res         = sum[WIDTH-1:0];
        sc_flags.carry = sum[WIDTH];
        sc_flags.ovf   = (op_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res         = diff[WIDTH-1:0];
        sc_flags.carry = ~diff[WIDTH];
        sc_flags.ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND:          sc_res = op_a & op_b;
      ALU_OR:           sc_res = op_a | op_b;
      ALU_XOR:          sc_res = op_a ^ op_b;
      ALU_NOTA:         sc_res = ~op_a;
      ALU_SLA, ALU_SLL: sc_res = op_a << shamt;
      ALU_SRA:          sc_res = $unsigned($signed(op_a) >>> shamt);
      ALU_SRL:          sc_res = op_a >> shamt;
      ALU_MUL:          sc_res = '0;
      ALU_DIVU: begin
        sc_res       = '1;
        sc_flags.dbz = 1'b1;
      end
      ALU_REMU: begin
        sc_res       = op_a;
        sc_flags.dbz = 1'b1;
      end
      default:          sc_flags.illegal = 1'b1;
    endcase
  end

  // Next-state and output-load decode
  always_comb begin
    state_n = state;
    load    = 1'b0;
    start   = 1'b0;
    res_n   = sc_res;
    flags_n = sc_flags;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (launch) begin
            start   = 1'b1;
            state_n = (mode == ALU_MUL) ? ST_MUL : ST_DIV;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (iter_done) begin
          load    = 1'b1;
          res_n   = iter_res;
          flags_n = '0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    flags_n.zero = (res_n == '0);
    flags_n.neg  = res_n[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Output register: loads on completion, otherwise holds until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags_q   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= res_n;
      flags_q   <= flags_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign zero    = flags_q.zero;
  assign neg     = flags_q.neg;
  assign carry   = flags_q.carry;
  assign ovf     = flags_q.ovf;
  assign dbz     = flags_q.dbz;
  assign illegal = flags_q.illegal;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_mul   (mode == ALU_MUL),
    .want_rem (mode == ALU_REMU),
    .a        (op_a),
    .b        (op_b),
    .done_c   (iter_done),
    .result_c (iter_res)
  );

endmodule
